hwt_seq_trigger: RTL and testbench

Sequential trigger stage sitting directly downstream of the combinational `non_active_hwt` rare-condition detector, whose output is Y = D & (C | (A & B)). It counts rising edges of that Y signal inside a sliding inactivity window. After THRESH qualifying edges it arms. The next edge asserts a payload-enable pulse for the payload stage that follows.

---
 rtl/hwt_seq_trigger.sv | 149 ++++++++++++++
 tb/tb_hwt_seq_trigger.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/hwt_seq_trigger.sv
// Counts y_in rising edges within an inactivity window, arms at THRESH, and pulses fire on the next edge; 1-cycle latency, no backpressure.
// Optional HWT_STICKY_FIRE_EN: FIRE becomes terminal until rst_n or clr.
module hwt_seq_trigger #(
   parameter int CNT_W       = 8,
   parameter int THRESH      = 16,
   parameter int WINDOW      = 64,
   parameter int FIRE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             y_in,
   input  logic             clr,
   output logic [CNT_W-1:0] trig_cnt,
   output logic             armed,
   output logic             fire
);

   localparam int WIN_W = $clog2(WINDOW + 1);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_COUNT = 2'd1;
   localparam logic [1:0] S_ARMED = 2'd2;
   localparam logic [1:0] S_FIRE  = 2'd3;

   localparam logic [CNT_W-1:0] CNT_THR  = CNT_W'(THRESH);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW - 1);
   localparam logic [WIN_W-1:0] WIN_ONE  = WIN_W'(1);

   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [CNT_W-1:0] cnt_inc;
   logic [WIN_W-1:0] win;
   logic [WIN_W-1:0] win_nxt;
   logic             y_q;
   logic             rise;

`ifndef HWT_STICKY_FIRE_EN
   localparam int FC_W = $clog2(FIRE_CYCLES + 1);
   localparam logic [FC_W-1:0] FC_LAST = FC_W'(FIRE_CYCLES - 1);
   localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);

   logic [FC_W-1:0] fcnt;
   logic [FC_W-1:0] fcnt_nxt;
`endif

   assign rise    = y_in & ~y_q;
   assign cnt_inc = cnt + CNT_ONE;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      win_nxt   = win;
`ifndef HWT_STICKY_FIRE_EN
      fcnt_nxt  = fcnt;
`endif
      if (clr) begin
         // clr wins over any coincident edge; y_q keeps sampling so a held-high y_in stays one edge
         state_nxt = S_IDLE;
         cnt_nxt   = '0;
         win_nxt   = '0;
`ifndef HWT_STICKY_FIRE_EN
         fcnt_nxt  = '0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               cnt_nxt = '0;
               if (rise) begin
                  cnt_nxt   = CNT_ONE;
                  win_nxt   = '0;
                  state_nxt = (THRESH == 1) ? S_ARMED : S_COUNT;
               end
            end
            S_COUNT: begin
               if (rise) begin
                  cnt_nxt = cnt_inc;
                  win_nxt = '0;
                  if (cnt_inc == CNT_THR) begin
                     state_nxt = S_ARMED;
                  end
               end else if (win == WIN_LAST) begin
                  state_nxt = S_IDLE;
                  cnt_nxt   = '0;
                  win_nxt   = '0;
               end else begin
                  win_nxt = win + WIN_ONE;
               end
            end
            S_ARMED: begin
               cnt_nxt = CNT_THR;
               if (rise) begin
                  state_nxt = S_FIRE;
`ifndef HWT_STICKY_FIRE_EN
                  fcnt_nxt  = '0;
`endif
               end
            end
            S_FIRE: begin
`ifndef HWT_STICKY_FIRE_EN
               if (fcnt == FC_LAST) begin
                  state_nxt = S_IDLE;
                  cnt_nxt   = '0;
                  fcnt_nxt  = '0;
               end else begin
                  fcnt_nxt = fcnt + FC_ONE;
               end
`endif
            end
            default: begin
               state_nxt = S_IDLE;
               cnt_nxt   = '0;
               win_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
         win   <= '0;
         y_q   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         win   <= win_nxt;
         y_q   <= y_in;
      end
   end

`ifndef HWT_STICKY_FIRE_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fcnt <= '0;
      end else begin
         fcnt <= fcnt_nxt;
      end
   end
`endif

   assign armed    = (state == S_ARMED);
   assign fire     = (state == S_FIRE);
   assign trig_cnt = cnt;

endmodule

// File: tb/tb_hwt_seq_trigger.sv
// Bench for hwt_seq_trigger with THRESH=3, WINDOW=8, FIRE_CYCLES=4; expectations written per cycle as
// strings: y_in, clr, expected trig_cnt digit, and flag ('.' none, 'A' armed, 'F' fire).
module tb_hwt_seq_trigger;

   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic       y_in  = 1'b0;
   logic       clr   = 1'b0;
   logic [7:0] trig_cnt;
   logic       armed;
   logic       fire;

   typedef struct packed {
      logic [7:0] cnt;
      logic       armed;
      logic       fire;
   } exp_t;

   exp_t exp_q[$];
   int   n_run  = 0;
   int   n_fail = 0;

   hwt_seq_trigger #(
      .CNT_W      (8),
      .THRESH     (3),
      .WINDOW     (8),
      .FIRE_CYCLES(4)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .y_in    (y_in),
      .clr     (clr),
      .trig_cnt(trig_cnt),
      .armed   (armed),
      .fire    (fire)
   );

   always #5 clk = ~clk;

   // Drive one cycle of stimulus, queue the expected post-clock outputs, and advance past the edge.
   task automatic drive(input byte yc, input byte cc, input byte nc, input byte fc);
      exp_t e;
      y_in    = (yc == "1");
      clr     = (cc == "1");
      e.cnt   = 8'(nc - 8'd48);
      e.armed = (fc == "A");
      e.fire  = (fc == "F");
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic y);
      rst_n = 1'b0;
      y_in  = y;
      clr   = 1'b0;
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      exp_t got, e;
      #1;
      rst_n = 1'b0;
      y_in  = 1'b0;
      #2;
      got = {trig_cnt, armed, fire};
      e   = '0;
      n_run++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL reset_async: got cnt=%0d armed=%b fire=%b, want 0 0 0", got.cnt, got.armed, got.fire);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         drive("0", "0", "0", ".");
         got = {trig_cnt, armed, fire};
         e   = exp_q.pop_front();
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL reset_idle[%0d]: got cnt=%0d armed=%b fire=%b, want cnt=%0d armed=%b fire=%b",
                     i, got.cnt, got.armed, got.fire, e.cnt, e.armed, e.fire);
         end
      end
   endtask

   task automatic test_window_timeout();
      string ys = "101000000000";
      string ns = "112222222200";
      exp_t  got, e;
      do_reset(1'b0);
      for (int i = 0; i < ys.len(); i++) begin
         drive(ys[i], "0", ns[i], ".");
         got = {trig_cnt, armed, fire};
         e   = exp_q.pop_front();
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL window_timeout[%0d]: got cnt=%0d armed=%b fire=%b, want cnt=%0d armed=%b fire=%b",
                     i, got.cnt, got.armed, got.fire, e.cnt, e.armed, e.fire);
         end
      end
   endtask

   task automatic test_held_high_clr();
      string ys = "11111111110111110110";
      string cs = "00000000000010000100";
      string ns = "11111111000100000000";
      exp_t  got, e;
      do_reset(1'b1);
      for (int i = 0; i < ys.len(); i++) begin
         drive(ys[i], cs[i], ns[i], ".");
         got = {trig_cnt, armed, fire};
         e   = exp_q.pop_front();
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL held_high_clr[%0d]: got cnt=%0d armed=%b fire=%b, want cnt=%0d armed=%b fire=%b",
                     i, got.cnt, got.armed, got.fire, e.cnt, e.armed, e.fire);
         end
      end
   endtask

   task automatic test_async_reset_in_fire();
      string ys = "10101010";
      string ns = "11223333";
      string fs = "....AAFF";
      exp_t  got, e;
      do_reset(1'b0);
      for (int i = 0; i < ys.len(); i++) begin
         drive(ys[i], "0", ns[i], fs[i]);
         got = {trig_cnt, armed, fire};
         e   = exp_q.pop_front();
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL async_rst_pre[%0d]: got cnt=%0d armed=%b fire=%b, want cnt=%0d armed=%b fire=%b",
                     i, got.cnt, got.armed, got.fire, e.cnt, e.armed, e.fire);
         end
      end
      // Mid-cycle, well before the next clock edge.
      #2;
      rst_n = 1'b0;
      exp_q.push_back('0);
      #1;
      got = {trig_cnt, armed, fire};
      e   = exp_q.pop_front();
      n_run++;
      if (got !== e) begin
         n_fail++;
         $display("FAIL async_rst_drop: got cnt=%0d armed=%b fire=%b, want 0 0 0", got.cnt, got.armed, got.fire);
      end
      y_in = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive("0", "0", "0", ".");
         got = {trig_cnt, armed, fire};
         e   = exp_q.pop_front();
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL async_rst_post[%0d]: got cnt=%0d armed=%b fire=%b, want cnt=%0d armed=%b fire=%b",
                     i, got.cnt, got.armed, got.fire, e.cnt, e.armed, e.fire);
         end
      end
   endtask

`ifndef HWT_STICKY_FIRE_EN
   task automatic test_arm_fire();
      string ys = "101010100000";
      string ns = "112233333300";
      string fs = "....AAFFFF..";
      exp_t  got, e;
      do_reset(1'b0);
      for (int i = 0; i < ys.len(); i++) begin
         drive(ys[i], "0", ns[i], fs[i]);
         got = {trig_cnt, armed, fire};
         e   = exp_q.pop_front();
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL arm_fire[%0d]: got cnt=%0d armed=%b fire=%b, want cnt=%0d armed=%b fire=%b",
                     i, got.cnt, got.armed, got.fire, e.cnt, e.armed, e.fire);
         end
      end
   endtask

   task automatic test_window_edge();
      string ys = "10100000001010000";
      string ns = "11222222223333330";
      string fs = "..........AAFFFF.";
      exp_t  got, e;
      do_reset(1'b0);
      for (int i = 0; i < ys.len(); i++) begin
         drive(ys[i], "0", ns[i], fs[i]);
         got = {trig_cnt, armed, fire};
         e   = exp_q.pop_front();
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL window_edge[%0d]: got cnt=%0d armed=%b fire=%b, want cnt=%0d armed=%b fire=%b",
                     i, got.cnt, got.armed, got.fire, e.cnt, e.armed, e.fire);
         end
      end
   endtask

   task automatic test_back_to_back();
      string ys = "10101010101010";
      string ns = "11223333330011";
      string fs = "....AAFFFF....";
      exp_t  got, e;
      do_reset(1'b0);
      for (int i = 0; i < ys.len(); i++) begin
         drive(ys[i], "0", ns[i], fs[i]);
         got = {trig_cnt, armed, fire};
         e   = exp_q.pop_front();
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got cnt=%0d armed=%b fire=%b, want cnt=%0d armed=%b fire=%b",
                     i, got.cnt, got.armed, got.fire, e.cnt, e.armed, e.fire);
         end
      end
   endtask
`else
   task automatic test_sticky_fire();
      string ys = "1010101";
      string ns = "1122333";
      string fs = "....AAF";
      exp_t  got, e;
      do_reset(1'b0);
      for (int i = 0; i < 64; i++) begin
         if (i < 7) begin
            drive(ys[i], "0", ns[i], fs[i]);
         end else if (i < 62) begin
            drive("0", "0", "3", "F");
         end else begin
            drive("0", (i == 62) ? "1" : "0", "0", ".");
         end
         got = {trig_cnt, armed, fire};
         e   = exp_q.pop_front();
         n_run++;
         if (got !== e) begin
            n_fail++;
            $display("FAIL sticky_fire[%0d]: got cnt=%0d armed=%b fire=%b, want cnt=%0d armed=%b fire=%b",
                     i, got.cnt, got.armed, got.fire, e.cnt, e.armed, e.fire);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
      test_window_timeout();
      test_held_high_clr();
      test_async_reset_in_fire();
`ifndef HWT_STICKY_FIRE_EN
      test_arm_fire();
      test_window_edge();
      test_back_to_back();
`else
      test_sticky_fire();
`endif
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
